fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Decoupling stage directly downstream of the program-counter generator in the RV32I core. Accepts fetch addresses, issues in-order instruction-memory reads, pairs each returned word with its PC, and presents {pc, inst} to decode through a valid/ready handshake. Supports a single-cycle flush on control-flow redirect, discarding all buffered and in-flight instructions.

## Interface
- XLEN, 32, address/data width
- DEPTH, 4, buffer entries; power of two, ≥2
- clk  in  1  core clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- fetch_valid  in  1  upstream PC valid
- fetch_pc  in  XLEN  address to fetch
- fetch_ready  out  1  PC accepted this cycle
- imem_req_valid  out  1  read request valid
- imem_req_addr  out  XLEN  read address (= fetch_pc)
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  read data valid; in-order, no backpressure
- imem_rsp_data  in  XLEN  instruction word
- flush  in  1  redirect; drop everything
- dec_valid  out  1  head entry holds a complete instruction
- dec_pc  out  XLEN  head PC
- dec_inst  out  XLEN  head instruction
- dec_ready  in  1  decode consumes head

## Operation
- Storage: DEPTH entries {pc, inst, filled}; head (pop), tail (alloc), fill pointers, each log2(DEPTH) bits, wrap modulo DEPTH; occupancy count 0..DEPTH.
- drop_cnt register, 0..DEPTH: responses still owed for flushed requests.
- Issue: imem_req_valid = fetch_valid & !flush & (count + drop_cnt < DEPTH); fetch_ready = same condition & imem_req_ready. imem_req_valid never depends on imem_req_ready.
- Request fire (valid & ready): write fetch_pc into tail entry, filled=0, tail++, count++.
- Response (imem_rsp_valid): if drop_cnt>0, discard, drop_cnt--; else write data into fill entry, filled=1, fill++.
- Pop (dec_valid & dec_ready): head++, count--.
- dec_valid = count>0 & head.filled; dec_pc/dec_inst = head entry fields (registered storage, no bypass).
- Simultaneous fire, response and pop in one cycle all take effect; count changes by (fire − pop).
- Response with drop_cnt==0 and no unfilled entry is illegal; assertion only.
- Flush (highest priority): count, head, tail, fill ← 0; all filled ← 0; drop_cnt ← drop_cnt + pending − rsp, where pending = allocated-unfilled entries before flush and rsp = imem_rsp_valid this cycle. No request fires and no pop is honoured in a flush cycle; dec_valid forced 0 during flush.
- Reset: pointers, count, drop_cnt, filled flags, stored pc/inst all 0. Outputs after reset: fetch_ready=0 until fetch_valid, imem_req_valid=0, imem_req_addr=0, dec_valid=0, dec_pc=0, dec_inst=0. Reset mid-transaction abandons in-flight responses (memory is reset with the core).

## Timing
- Request issue: combinational from fetch_valid, zero cycle.
- Response in cycle N → dec_valid=1 in N+1 if entry is head.
- Pop in cycle N → next entry visible N+1.
- Flush in cycle N → dec_valid=0 in N; first post-flush request may fire N+1 if drop_cnt < DEPTH.
- Full throughput: 1 instruction/cycle with single-cycle memory and dec_ready=1.
- Throttle: count + drop_cnt == DEPTH → fetch_ready=0 (full boundary).

## Test plan
- Streaming: PCs 0x0,0x4,0x8… with 1-cycle memory, dec_ready=1 → dec_pc/inst pairs in order, one per cycle after 2-cycle fill latency, no gaps.
- Backpressure: dec_ready=0 for 10 cycles → exactly 4 requests issued, fetch_ready=0 afterwards; release → 4 entries drain in order, then issue resumes.
- Variable latency: responses delayed 0–3 cycles randomly, PCs 0x100.. → each dec_inst matches memory model at its dec_pc; head never shown before filled.
- Flush with 3 outstanding: flush, then new PC 0x200 → 3 stale responses discarded, first dec_pc=0x200 with correct word; flush cycle coincident with a response → drop_cnt=2.
- Wrap-around: 20 instructions through DEPTH=4 with random dec_ready → pointer wrap, count never exceeds 4, no loss or duplication.
- Sync reset asserted mid-stream for 1 cycle → next cycle dec_valid=0, imem_req_valid=0 until fetch_valid, buffer empty.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer: decouples the PC generator from decode, pairing each
// in-order imem response with its PC; single-cycle flush on redirect.
module fetch_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            fetch_ready,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            flush,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_inst,
  input  logic            dec_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

  logic [XLEN-1:0]  pc_q   [DEPTH];
  logic [XLEN-1:0]  inst_q [DEPTH];
  logic [DEPTH-1:0] filled_q;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pend_q, pend_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW:0] occ;
  logic        fire;
  logic        pop;
  logic        rsp_keep;
  logic        rsp_drop;

  // Stale responses still owed occupy slots until they drain.
  assign occ = {1'b0, count_q} + {1'b0, drop_q};

  assign imem_req_valid = fetch_valid & ~flush & (occ < FULL);
  assign fetch_ready    = imem_req_valid & imem_req_ready;
  assign imem_req_addr  = fetch_pc;

  assign dec_valid = ~flush & (count_q != '0) & filled_q[head_q];
  assign dec_pc    = pc_q[head_q];
  assign dec_inst  = inst_q[head_q];

  assign fire     = fetch_ready;
  assign pop      = dec_valid & dec_ready;
  assign rsp_drop = imem_rsp_valid & (drop_q != '0);
  assign rsp_keep = imem_rsp_valid & (drop_q == '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    count_d = count_q;
    pend_d  = pend_q;
    drop_d  = drop_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      fill_d  = '0;
      count_d = '0;
      pend_d  = '0;
      drop_d  = drop_q + pend_q - CW'(imem_rsp_valid);
    end else begin
      if (fire)     tail_d = tail_q + PW'(1);
      if (pop)      head_d = head_q + PW'(1);
      if (rsp_keep) fill_d = fill_q + PW'(1);
      if (rsp_drop) drop_d = drop_q - CW'(1);
      count_d = count_q + CW'(fire) - CW'(pop);
      pend_d  = pend_q + CW'(fire) - CW'(rsp_keep);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      drop_q   <= '0;
      filled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      if (fire)     pc_q[tail_q]   <= fetch_pc;
      if (rsp_keep) inst_q[fill_q] <= imem_rsp_data;
      if (flush) begin
        filled_q <= '0;
      end else begin
        if (fire)     filled_q[tail_q] <= 1'b0;
        if (rsp_keep) filled_q[fill_q] <= 1'b1;
      end
    end
  end

  // A kept response must always have an allocated, unfilled entry.
  a_rsp_owed: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && drop_q == '0 && pend_q == '0));

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed vector table plus randomized traffic checked
// against a queue-based scoreboard and an in-order memory model.
module tb_fetch_buffer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int NV    = 21;
  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_pc;
  logic            fetch_ready;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            flush;
  logic            dec_valid;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_inst;
  logic            dec_ready;

  fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .flush(flush),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_inst(dec_inst),
    .dec_ready(dec_ready)
  );

  typedef struct {
    logic fv; logic [31:0] pc; logic rr; logic rsp; logic [31:0] rdata;
    logic fl; logic dr;
    logic efr; logic erv; logic edv; logic cd;
    logic [31:0] epc; logic [31:0] einst;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int nfire = 0;
  int npop  = 0;
  logic last_fire;

  logic [31:0] sq[$];
  int          nfill = 0;
  int          stale = 0;
  mreq_t       mq[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic clear_model();
    sq.delete();
    mq.delete();
    nfill = 0;
    stale = 0;
  endtask

  task automatic do_reset(input int n);
    rst            = 1'b1;
    fetch_valid    = 1'b0;
    fetch_pc       = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    flush          = 1'b0;
    dec_ready      = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  // One cycle: memory model drives the response, outputs are checked
  // against the scoreboard, then the scoreboard advances at the edge.
  task automatic mstep(input int lat);
    logic e_rv, e_fr, e_dv, rsp, pop;
    int   occ;
    rsp = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? inst_of(mq[0].a) : $urandom();
    #1;
    occ  = sq.size() + stale;
    e_rv = fetch_valid && !flush && (occ < DEPTH);
    e_fr = e_rv && imem_req_ready;
    e_dv = !flush && (nfill > 0);
    chk1("imem_req_valid", imem_req_valid, e_rv);
    chk1("fetch_ready", fetch_ready, e_fr);
    chk1("dec_valid", dec_valid, e_dv);
    if (e_dv) begin
      chk("dec_pc", dec_pc, sq[0]);
      chk("dec_inst", dec_inst, inst_of(sq[0]));
    end
    if (e_rv) chk("imem_req_addr", imem_req_addr, fetch_pc);
    if (fetch_ready === 1'b1) nfire++;
    if (dec_valid === 1'b1 && dec_ready) npop++;
    pop       = e_dv && dec_ready;
    last_fire = e_fr;
    @(posedge clk);
    if (rsp) begin
      void'(mq.pop_front());
      if (stale > 0) stale--;
      else nfill++;
    end
    if (flush) begin
      stale += sq.size() - nfill;
      sq.delete();
      nfill = 0;
    end else begin
      if (e_fr) begin
        sq.push_back(fetch_pc);
        mq.push_back('{a: fetch_pc,
                       due: cyc + 1 + int'($urandom_range(0, lat))});
      end
      if (pop) begin
        void'(sq.pop_front());
        nfill--;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    vec_t        tv[NV];
    logic [31:0] pc_next;

    //        fv pc        rr rsp rdata         fl dr  efr erv edv cd  epc       einst
    tv[0]  = '{N, 32'h0,   N, N, 32'h0,         N, N,  N, N, N, Y, 32'h0,   32'h0};
    tv[1]  = '{Y, 32'h10,  Y, N, 32'h0,         N, N,  Y, Y, N, N, 32'h0,   32'h0};
    tv[2]  = '{Y, 32'h14,  N, Y, 32'hAAAA0001,  N, N,  N, Y, N, N, 32'h0,   32'h0};
    tv[3]  = '{N, 32'h0,   N, N, 32'h0,         N, N,  N, N, Y, Y, 32'h10,  32'hAAAA0001};
    tv[4]  = '{Y, 32'h14,  Y, N, 32'h0,         N, Y,  Y, Y, Y, Y, 32'h10,  32'hAAAA0001};
    tv[5]  = '{Y, 32'h18,  Y, N, 32'h0,         N, Y,  Y, Y, N, N, 32'h0,   32'h0};
    tv[6]  = '{Y, 32'h1C,  Y, Y, 32'hBBBB0002,  N, N,  Y, Y, N, N, 32'h0,   32'h0};
    tv[7]  = '{Y, 32'h20,  Y, N, 32'h0,         N, N,  Y, Y, Y, Y, 32'h14,  32'hBBBB0002};
    tv[8]  = '{Y, 32'h24,  Y, N, 32'h0,         N, N,  N, N, Y, Y, 32'h14,  32'hBBBB0002};
    tv[9]  = '{Y, 32'h24,  Y, Y, 32'hCCCC0003,  Y, Y,  N, N, N, N, 32'h0,   32'h0};
    tv[10] = '{Y, 32'h200, Y, N, 32'h0,         N, N,  Y, Y, N, N, 32'h0,   32'h0};
    tv[11] = '{Y, 32'h204, Y, N, 32'h0,         N, N,  Y, Y, N, N, 32'h0,   32'h0};
    tv[12] = '{Y, 32'h208, Y, N, 32'h0,         N, N,  N, N, N, N, 32'h0,   32'h0};
    tv[13] = '{Y, 32'h208, Y, Y, 32'h0BAD0BAD,  N, N,  N, N, N, N, 32'h0,   32'h0};
    tv[14] = '{Y, 32'h208, Y, Y, 32'h0BAD0BAD,  N, N,  Y, Y, N, N, 32'h0,   32'h0};
    tv[15] = '{N, 32'h0,   N, Y, 32'hDDDD0200,  N, N,  N, N, N, N, 32'h0,   32'h0};
    tv[16] = '{N, 32'h0,   N, Y, 32'hEEEE0204,  N, Y,  N, N, Y, Y, 32'h200, 32'hDDDD0200};
    tv[17] = '{N, 32'h0,   N, N, 32'h0,         N, Y,  N, N, Y, Y, 32'h204, 32'hEEEE0204};
    tv[18] = '{N, 32'h0,   N, Y, 32'hFFFF0208,  N, Y,  N, N, N, N, 32'h0,   32'h0};
    tv[19] = '{N, 32'h0,   N, N, 32'h0,         N, Y,  N, N, Y, Y, 32'h208, 32'hFFFF0208};
    tv[20] = '{N, 32'h0,   N, N, 32'h0,         N, N,  N, N, N, N, 32'h0,   32'h0};

    do_reset(2);
    for (int i = 0; i < NV; i++) begin
      fetch_valid    = tv[i].fv;
      fetch_pc       = tv[i].pc;
      imem_req_ready = tv[i].rr;
      imem_rsp_valid = tv[i].rsp;
      imem_rsp_data  = tv[i].rdata;
      flush          = tv[i].fl;
      dec_ready      = tv[i].dr;
      #1;
      chk1($sformatf("vec%0d.fetch_ready", i), fetch_ready, tv[i].efr);
      chk1($sformatf("vec%0d.imem_req_valid", i), imem_req_valid, tv[i].erv);
      chk1($sformatf("vec%0d.dec_valid", i), dec_valid, tv[i].edv);
      if (tv[i].cd) begin
        chk($sformatf("vec%0d.dec_pc", i), dec_pc, tv[i].epc);
        chk($sformatf("vec%0d.dec_inst", i), dec_inst, tv[i].einst);
      end
      @(posedge clk);
      @(negedge clk);
    end

    // streaming, single-cycle memory
    do_reset(1);
    pc_next = 32'h0; dec_ready = 1'b1; imem_req_ready = 1'b1; npop = 0;
    for (int i = 0; i < 24; i++) begin
      fetch_valid = 1'b1;
      fetch_pc    = pc_next;
      mstep(0);
      if (last_fire) pc_next += 32'd4;
    end
    chk("stream_pops", npop, 32'd22);

    // backpressure then drain then resume
    do_reset(1);
    pc_next = 32'h40; dec_ready = 1'b0; imem_req_ready = 1'b1;
    nfire = 0; npop = 0;
    for (int i = 0; i < 10; i++) begin
      fetch_valid = 1'b1;
      fetch_pc    = pc_next;
      mstep(0);
      if (last_fire) pc_next += 32'd4;
    end
    chk("bp_fires", nfire, 32'd4);
    chk1("bp_ready_low", fetch_ready, 1'b0);
    dec_ready = 1'b1; fetch_valid = 1'b0;
    for (int i = 0; i < 4; i++) mstep(0);
    chk("bp_drain", npop, 32'd4);
    for (int i = 0; i < 6; i++) begin
      fetch_valid = 1'b1;
      fetch_pc    = pc_next;
      mstep(0);
      if (last_fire) pc_next += 32'd4;
    end

    // variable latency, random flushes, one mid-stream reset
    do_reset(1);
    pc_next = 32'h100;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        fetch_valid = 1'b0; flush = 1'b0; imem_rsp_valid = 1'b0;
        #1;
        chk1("rst_dec_valid", dec_valid, 1'b0);
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_dec_inst", dec_inst, 32'h0);
        mstep(3);
        mstep(3);
      end
      fetch_valid    = ($urandom_range(0, 9) < 8);
      imem_req_ready = ($urandom_range(0, 9) < 8);
      dec_ready      = ($urandom_range(0, 9) < 7);
      flush          = ($urandom_range(0, 29) == 0);
      fetch_pc       = pc_next;
      mstep(3);
      if (flush) pc_next = 32'h200 + (32'($urandom_range(0, 63)) << 2);
      else if (last_fire) pc_next += 32'd4;
    end
    flush = 1'b0;

    // wrap-around with random decode stalls, then full drain
    do_reset(1);
    pc_next = 32'h800; imem_req_ready = 1'b1; nfire = 0; npop = 0;
    for (int i = 0; i < 60; i++) begin
      fetch_valid = ($urandom_range(0, 9) < 8);
      dec_ready   = ($urandom_range(0, 1) == 1);
      fetch_pc    = pc_next;
      mstep(1);
      if (last_fire) pc_next += 32'd4;
    end
    fetch_valid = 1'b0; dec_ready = 1'b1;
    for (int i = 0; i < 12; i++) mstep(1);
    chk("wrap_no_loss", npop, nfire);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
